// File: rtl/bta_pkg.sv
// Shared sizing and FSM encoding for the binary-tree adder operand sequencer.
package bta_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned M      = 16;
    localparam int unsigned SUM_W  = M + 3;
    localparam int unsigned LAT    = 3;
    localparam int unsigned CNT_W  = $clog2(N);
    localparam int unsigned WCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        LAUNCH,
        WAIT,
        CAPTURE,
        HOLD
    } state_e;

endpackage

// File: rtl/bta_frame_buf.sv
// N x M operand slot bank: one indexed write per cycle, optional clear of all slots above it.
module bta_frame_buf
    import bta_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_idx,
    input  logic [M-1:0]     wr_data,
    input  logic             clr_above,
    output logic [N*M-1:0]   slots
);

    logic [M-1:0] slot_q [N];
    logic [M-1:0] slot_d [N];

    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            slot_d[k] = slot_q[k];
            if (wr_en) begin
                if (CNT_W'(k) == wr_idx) begin
                    slot_d[k] = wr_data;
                end else if (clr_above && (CNT_W'(k) > wr_idx)) begin
                    slot_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N); k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_slot
        assign slots[g*M +: M] = slot_q[g];
    end

endmodule

// File: rtl/bta_operand_sequencer.sv
// Serial-to-parallel front end and result port for the N-operand tree adder.
// Define BTA_SEQ_PARTIAL_FRAME_EN to add in_last and allow short, zero-padded frames.
module bta_operand_sequencer
    import bta_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_data,
`ifdef BTA_SEQ_PARTIAL_FRAME_EN
    input  logic             in_last,
`endif
    output logic [N*M-1:0]   op_bus,
    output logic             add_cin,
    input  logic [SUM_W-1:0] add_sum,
    input  logic             add_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_ovf
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic                ovf_q, ovf_d;
    logic                accept;
    logic                end_beat;
    logic                clr_above;

    assign accept = in_valid && in_ready;

`ifdef BTA_SEQ_PARTIAL_FRAME_EN
    assign end_beat  = (cnt_q == CNT_W'(N - 1)) || in_last;
    assign clr_above = in_last;
`else
    assign end_beat  = (cnt_q == CNT_W'(N - 1));
    assign clr_above = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FILL;
            FILL:    if (accept && end_beat) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (wcnt_q == WCNT_W'(LAT - 1)) state_d = CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD:    if (out_ready) state_d = FILL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == FILL);
        out_valid = (state_q == HOLD);
    end

    // The slot count doubles as the write index, so it must clear when the frame closes.
    always_comb begin
        cnt_d  = '0;
        wcnt_d = '0;
        sum_d  = sum_q;
        ovf_d  = ovf_q;
        if (state_q == FILL) begin
            cnt_d = cnt_q;
            if (accept) begin
                cnt_d = end_beat ? '0 : cnt_q + CNT_W'(1);
            end
        end
        if (state_q == WAIT) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
        if (state_q == CAPTURE) begin
            sum_d = add_sum;
            ovf_d = add_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wcnt_q <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wcnt_q <= wcnt_d;
            sum_q  <= sum_d;
            ovf_q  <= ovf_d;
        end
    end

    bta_frame_buf u_frame_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept),
        .wr_idx    (cnt_q),
        .wr_data   (in_data),
        .clr_above (clr_above),
        .slots     (op_bus)
    );

    assign add_cin = 1'b0;
    assign out_sum = sum_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_bta_operand_sequencer.sv
// Bench for bta_operand_sequencer with a LAT-stage registered behavioural tree adder.
`timescale 1ns/1ps
module tb_bta_operand_sequencer;
    import bta_pkg::*;

`ifdef BTA_SEQ_PARTIAL_FRAME_EN
    localparam bit PARTIAL = 1'b1;
`else
    localparam bit PARTIAL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [M-1:0]     in_data;
    logic             in_last_s;
    logic [N*M-1:0]   op_bus;
    logic             add_cin;
    logic [SUM_W-1:0] add_sum;
    logic             add_carry;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic             out_ovf;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int valid_cyc = 0;
    int hs_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bta_operand_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef BTA_SEQ_PARTIAL_FRAME_EN
        .in_last   (in_last_s),
`endif
        .op_bus    (op_bus),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    // Behavioural tree adder: plain sum, delayed LAT clocks.
    logic [SUM_W:0] tree_in;
    logic [SUM_W:0] pipe [LAT];

    always_comb begin
        tree_in = '0;
        for (int k = 0; k < int'(N); k++) tree_in += (SUM_W + 1)'(op_bus[k*M +: M]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LAT); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tree_in;
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign add_sum   = pipe[LAT-1][SUM_W-1:0];
    assign add_carry = pipe[LAT-1][SUM_W];

    task automatic chk(input string name, input logic [N*M-1:0] act, input logic [N*M-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frames collected from observed handshakes, result due LAT+3 after last beat.
    logic [M-1:0]   mf [N];
    logic [N*M-1:0] mvec = '0;
    logic [SUM_W:0] exp_tot = '0;
    int  mcnt = 0;
    bit  busy = 1'b0;
    int  due = 0;
    int  launch = 0;
    int  ready_from = 0;
    bit  exp_ready;
    bit  exp_valid;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            mcnt = 0;
            ready_from = cyc + 2;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sum", out_sum, 0);
            chk("rst_out_ovf", out_ovf, 0);
            chk("rst_op_bus", op_bus, 0);
        end else begin
            exp_ready = !busy && (cyc >= ready_from);
            exp_valid = busy && (cyc >= due);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                chk("out_sum", out_sum, exp_tot[SUM_W-1:0]);
                chk("out_ovf", out_ovf, exp_tot[SUM_W]);
            end
            if (busy && cyc >= launch && cyc < due) chk("op_bus_stable", op_bus, mvec);
            if (in_valid && exp_ready) begin
                mf[mcnt] = in_data;
                mcnt++;
                if (mcnt == int'(N) || (PARTIAL && in_last_s)) begin
                    for (int k = mcnt; k < int'(N); k++) mf[k] = '0;
                    exp_tot = '0;
                    for (int k = 0; k < int'(N); k++) begin
                        exp_tot += (SUM_W + 1)'(mf[k]);
                        mvec[k*M +: M] = mf[k];
                    end
                    busy = 1'b1;
                    launch = cyc + 1;
                    due = cyc + int'(LAT) + 3;
                    mcnt = 0;
                end
            end
            if (exp_valid && out_ready) begin
                busy = 1'b0;
                ready_from = cyc + 1;
            end
        end
    end

    task automatic beat(input logic [M-1:0] d, input logic last, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        in_data   = d;
        in_last_s = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                in_last_s = 1'b0;
                return;
            end
        end
        n_chk++;
        n_err++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, want 1");
        in_valid  = 1'b0;
        in_last_s = 1'b0;
    endtask

    task automatic wait_result(input int hold, output logic [SUM_W-1:0] got, output logic gov);
        bit seen;
        seen = 1'b0;
        got  = '0;
        gov  = 1'b0;
        out_ready = (hold == 0);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen      = 1'b1;
                valid_cyc = cyc;
                got       = out_sum;
                gov       = out_ovf;
            end
        end
        if (!seen) begin
            n_chk++;
            n_err++;
            $display("FAIL result_timeout: got out_valid=0 for 200 cycles, want 1");
            out_ready = 1'b0;
            return;
        end
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data  = 16'h0063;
            repeat (hold) @(posedge clk);
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_sum", out_sum, got);
            chk("hold_in_ready", in_ready, 0);
            out_ready = 1'b1;
        end
        hs_cyc = valid_cyc + hold;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    int gaps [8] = '{0, 2, 1, 3, 0, 1, 2, 4};
    logic [SUM_W-1:0] got;
    logic             gov;
    int               last_acc;
    logic [N*M-1:0]   part_exp;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last_s = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("add_cin", add_cin, 0);
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) beat(M'(i), 1'b0, 0);
        last_acc = acc_cyc;
        wait_result(0, got, gov);
        chk("sum_1to8", got, 36);
        chk("ovf_1to8", gov, 0);
        chk("latency_1to8", valid_cyc - last_acc, LAT + 3);

        for (int i = 0; i < 8; i++) beat(16'hFFFF, 1'b0, 0);
        wait_result(5, got, gov);
        chk("sum_allones", got, 19'h7FFF8);
        chk("ovf_allones", gov, 0);

        for (int i = 0; i < 8; i++) begin
            beat(M'(10 * (i + 1)), 1'b0, gaps[i]);
            if (i == 0) chk("first_accept_after_hs", acc_cyc, hs_cyc + 1);
        end
        wait_result(0, got, gov);
        chk("sum_gaps", got, 360);

        for (int i = 0; i < 8; i++) beat(16'd5, 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_sum", out_sum, 0);
        chk("async_rst_op_bus", op_bus, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) beat(16'd2, 1'b0, 0);
        wait_result(0, got, gov);
        chk("sum_after_rst", got, 16);

`ifdef BTA_SEQ_PARTIAL_FRAME_EN
        beat(16'd5, 1'b0, 0);
        beat(16'd6, 1'b0, 0);
        beat(16'd7, 1'b1, 0);
        part_exp = '0;
        part_exp[47:0] = 48'h0007_0006_0005;
        chk("partial_slots", op_bus, part_exp);
        wait_result(0, got, gov);
        chk("sum_partial", got, 18);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
